multicycle_adder_subtractor_module: RTL and testbench

MULTICYCLE_ADDER_SUBTRACTOR_MODULE -- requirements
Module: multicycle_adder_subtractor_module

---
 rtl/multicycle_adder_subtractor_module_if.sv | 36 +++
 rtl/multicycle_adder_subtractor_module.sv | 130 +++++++++++++
 tb/tb_multicycle_adder_subtractor_module.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_subtractor_module_if.sv
// Handshake/data bundle for multicycle_adder_subtractor_module.
//   master : requester side, drives start/sub/a/b/cin and observes the result
//   slave  : the adder itself, observes the request and drives busy/done/sum/cout/overflow
//   start    request a new operation (sampled on the rising clock edge)
//   sub      0 = a+b+cin, 1 = a-b-cin (sampled with start)
//   a, b     operands (sampled with start)
//   cin      carry-in / borrow-in (sampled with start)
//   busy     operation in progress
//   done     one-cycle pulse marking a new result
//   sum      registered result
//   cout     registered carry-out of the MSB (sub mode: 1 = no borrow)
//   overflow registered two's-complement overflow flag
interface multicycle_adder_subtractor_module_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/multicycle_adder_subtractor_module.sv
// Multicycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// so a WIDTH-bit operation takes N = WIDTH/CHUNK RUN cycles followed by a
// single DONE cycle. WIDTH must be an integer multiple of CHUNK.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears all state and results
//   bus    slave side of multicycle_adder_subtractor_module_if
//          (start/sub/a/b/cin in, busy/done/sum/cout/overflow out)
module multicycle_adder_subtractor_module #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                                 clk,
  input logic                                 reset,
  multicycle_adder_subtractor_module_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic             carry_q;  // already inverted borrow for subtraction
  logic [WIDTH-1:0] acc_q;    // partial sums of the chunks done so far
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] acc_d;

  // One CHUNK-wide ripple step: {carry_out, partial_sum}.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Current chunk datapath
  always_comb begin
    a_chunk          = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_chunk          = b_q[int'(k_q)*CHUNK +: CHUNK];
    {c_out, s_chunk} = add_chunk(a_chunk, b_chunk, carry_q);
    // Carry into the top bit of this chunk, recovered from its sum bit; only
    // meaningful on the last chunk where that bit is bit WIDTH-1.
    c_msb            = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    acc_d            = acc_q;
    acc_d[int'(k_q)*CHUNK +: CHUNK] = s_chunk;
  end

  // Control FSM and registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            // a - b - cin == a + ~b + ~cin (mod 2^WIDTH)
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ^ bus.cin;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // start is deliberately not looked at here.
          acc_q   <= acc_d;
          carry_q <= c_out;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            sum_q   <= acc_d;
            cout_q  <= c_out;
            ovf_q   <= c_msb ^ c_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q     <= k_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder_subtractor_module.sv
// Self-checking bench for multicycle_adder_subtractor_module (WIDTH=32, CHUNK=8).
module tb_multicycle_adder_subtractor_module;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_adder_subtractor_module_if #(.WIDTH(WIDTH)) bus ();

  multicycle_adder_subtractor_module #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pending result of the accepted op, and the
  // result the outputs should currently hold.
  logic [31:0] pend_sum, held_sum;
  logic        pend_cout, held_cout;
  logic        pend_ovf, held_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: signed/unsigned integer math, no chunking.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic c);
    logic [63:0] ua, ub, ures;
    longint      sa, sb, sres;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      ures      = ua + ub + 64'(c);
      pend_cout = (ures >= 64'h1_0000_0000);
      sres      = sa + sb + longint'(c);
    end else begin
      pend_cout = (ua >= ub + 64'(c));
      sres      = sa - sb - longint'(c);
    end
    pend_sum = sres[31:0];
    pend_ovf = (sres > SMAX) || (sres < SMIN);
  endfunction

  // Drive a request for one edge; caller is #1 after an edge (or at start).
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    model(s, a, b, c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sub   = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.cin   = 1'($urandom);
    chk("acc_busy", 64'(bus.busy), 64'd1);
    chk("acc_done", 64'(bus.done), 64'd0);
  endtask

  // Step through the N RUN edges; ends #1 after the completion edge.
  task automatic run_to_done(input bit noise);
    for (int i = 1; i <= N; i++) begin
      if (noise) begin
        bus.start = 1'b1;
        bus.sub   = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.cin   = 1'($urandom);
      end
      @(posedge clk); #1;
      if (i < N) begin
        chk("run_busy", 64'(bus.busy), 64'd1);
        chk("run_done", 64'(bus.done), 64'd0);
        chk("run_hold_sum", 64'(bus.sum), 64'(held_sum));
        chk("run_hold_cout", 64'(bus.cout), 64'(held_cout));
        chk("run_hold_ovf", 64'(bus.overflow), 64'(held_ovf));
      end else begin
        chk("fin_done", 64'(bus.done), 64'd1);
        chk("fin_busy", 64'(bus.busy), 64'd0);
        chk("fin_sum", 64'(bus.sum), 64'(pend_sum));
        chk("fin_cout", 64'(bus.cout), 64'(pend_cout));
        chk("fin_ovf", 64'(bus.overflow), 64'(pend_ovf));
        held_sum  = pend_sum;
        held_cout = pend_cout;
        held_ovf  = pend_ovf;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_sum", 64'(bus.sum), 64'(held_sum));
  endtask

  task automatic directed(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic [31:0] e_sum,
                          input logic e_cout, input logic e_ovf);
    launch(s, a, b, c);
    run_to_done(1'b0);
    chk({tag, "_sum"}, 64'(bus.sum), 64'(e_sum));
    chk({tag, "_cout"}, 64'(bus.cout), 64'(e_cout));
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(e_ovf));
    idle_check();
  endtask

  logic [31:0] corner [5];

  function automatic logic [31:0] pick();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel < 5) return corner[sel];
    return $urandom;
  endfunction

  initial begin
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h0000_0001;
    held_sum  = '0; held_cout = 1'b0; held_ovf = 1'b0;
    pend_sum  = '0; pend_cout = 1'b0; pend_ovf = 1'b0;

    // Reset, with start asserted to show reset wins.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h1111_1111;
    bus.cin   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    idle_check();

    directed("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_neg", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("sub_bin", 1'b1, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000C, 1'b1, 1'b0);

    // start held high through RUN with other operands: ignored, one done pulse.
    launch(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1);
    run_to_done(1'b1);
    chk("hold_sum", 64'(bus.sum), 64'h31);
    idle_check();

    // Back-to-back: new start accepted in the DONE cycle.
    launch(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    run_to_done(1'b0);
    launch(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_to_done(1'b0);
    chk("b2b_sum", 64'(bus.sum), 64'h2);
    idle_check();

    // Reset two cycles into RUN: abandoned, no done, results cleared.
    launch(1'b0, 32'h0000_1234, 32'h0000_5678, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_sum", 64'(bus.sum), 64'd0);
    chk("mid_rst_cout", 64'(bus.cout), 64'd0);
    for (int i = 0; i < N + 2; i++) idle_check();
    directed("post_rst", 1'b0, 32'h0000_0100, 32'h0000_0023, 1'b0, 32'h0000_0123, 1'b0, 1'b0);

    // Randomized mix: plain, start-noise during RUN, and back-to-back.
    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      launch(1'($urandom), pick(), pick(), 1'($urandom));
      run_to_done(mode == 1);
      if (mode != 2) idle_check();
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
